// File: rtl/pea_fifo_ext.sv
// Single-clock circular-buffer FIFO with population/free-space counts, almost flags,
// sticky overflow/underflow and a choice of registered or first-word-fall-through read.
module pea_fifo_ext #(
    parameter int buffer_size = 1024,
    parameter int width       = 16,
    parameter int fwft        = 0,
    parameter int af_level    = buffer_size - 2,
    parameter int ae_level    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            wr_en,
    input  logic                            rd_en,
    input  logic [width-1:0]                data_in,
    output logic [$clog2(buffer_size):0]    population,
    output logic [$clog2(buffer_size):0]    free_space,
    output logic [width-1:0]                data_out,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int AW = $clog2(buffer_size);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(buffer_size);
    localparam logic [AW:0]   AF_C    = (AW+1)'(af_level);
    localparam logic [AW:0]   AE_C    = (AW+1)'(ae_level);
    localparam logic [AW:0]   CNT1_C  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR1_C  = AW'(1);

    logic [width-1:0] mem_q [buffer_size];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      pop_q, pop_d;
    logic [width-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_acc, wr_acc;

    assign empty        = (pop_q == '0);
    assign full         = (pop_q == DEPTH_C);
    assign almost_full  = (pop_q >= AF_C);
    assign almost_empty = (pop_q <= AE_C);
    assign population   = pop_q;
    assign free_space   = DEPTH_C - pop_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A write into a full FIFO is still legal when a read frees the slot on the same edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_d    = pop_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pop_d    = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR1_C;
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR1_C;
                dout_d   = mem_q[rd_ptr_q];
            end
            if (wr_acc && !rd_acc)      pop_d = pop_q + CNT1_C;
            else if (rd_acc && !wr_acc) pop_d = pop_q - CNT1_C;
            if (wr_en && !wr_acc) ovf_d = 1'b1;
            if (rd_en && !rd_acc) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pop_q    <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pop_q    <= pop_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr && !rst) mem_q[wr_ptr_q] <= data_in;
    end

    // In fall-through mode the head word is shown directly; a fresh write only
    // becomes visible once the population register has counted it.
    assign data_out = (fwft != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : dout_q;

endmodule

// File: tb/tb_pea_fifo_ext.sv
// Directed bench for pea_fifo_ext: one registered-read instance (a_) and one
// fall-through instance (b_), both depth 4 with af_level=3 and ae_level=1.
module tb_pea_fifo_ext;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         a_clr = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [W-1:0] a_din = '0;
    logic [2:0]   a_pop, a_free;
    logic [W-1:0] a_dout;
    logic         a_empty, a_full, a_af, a_ae, a_ovf, a_udf;

    logic         b_clr = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [W-1:0] b_din = '0;
    logic [2:0]   b_pop, b_free;
    logic [W-1:0] b_dout;
    logic         b_empty, b_full, b_af, b_ae, b_ovf, b_udf;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    pea_fifo_ext #(.buffer_size(4), .width(W), .fwft(0), .af_level(3), .ae_level(1)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .wr_en(a_wr), .rd_en(a_rd), .data_in(a_din),
        .population(a_pop), .free_space(a_free), .data_out(a_dout), .empty(a_empty),
        .full(a_full), .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ovf),
        .underflow(a_udf)
    );

    pea_fifo_ext #(.buffer_size(4), .width(W), .fwft(1), .af_level(3), .ae_level(1)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .wr_en(b_wr), .rd_en(b_rd), .data_in(b_din),
        .population(b_pop), .free_space(b_free), .data_out(b_dout), .empty(b_empty),
        .full(b_full), .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf),
        .underflow(b_udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic w, input logic r, input logic [W-1:0] d);
        a_wr = w; a_rd = r; a_din = d;
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic clr_a();
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
    endtask

    task automatic step_b(input logic w, input logic r, input logic [W-1:0] d);
        b_wr = w; b_rd = r; b_din = d;
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_pop"},   a_pop,   3'd0);
        check({tag, "_empty"}, a_empty, 1'b1);
        check({tag, "_ae"},    a_ae,    1'b1);
        check({tag, "_full"},  a_full,  1'b0);
        check({tag, "_af"},    a_af,    1'b0);
        check({tag, "_free"},  a_free,  3'd4);
        check({tag, "_dout"},  a_dout,  16'h0000);
        check({tag, "_ovf"},   a_ovf,   1'b0);
        check({tag, "_udf"},   a_udf,   1'b0);
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] e;

        // reset state
        #3;
        check_reset_a("rst");
        check("rst_b_dout",  b_dout,  16'h0000);
        check("rst_b_empty", b_empty, 1'b1);
        #4 rst = 1'b0;

        // fill, almost-full and full
        step_a(1, 0, 16'h0011);
        check("w1_pop", a_pop, 3'd1);
        check("w1_ae",  a_ae,  1'b1);
        step_a(1, 0, 16'h0022);
        check("w2_pop", a_pop, 3'd2);
        check("w2_ae",  a_ae,  1'b0);
        check("w2_af",  a_af,  1'b0);
        step_a(1, 0, 16'h0033);
        check("w3_pop",  a_pop,  3'd3);
        check("w3_af",   a_af,   1'b1);
        check("w3_full", a_full, 1'b0);
        step_a(1, 0, 16'h0044);
        check("w4_pop",  a_pop,  3'd4);
        check("w4_full", a_full, 1'b1);
        check("w4_free", a_free, 3'd0);

        // write while full is rejected; simultaneous rd+wr while full is accepted
        step_a(1, 0, 16'h0099);
        check("ovf_set", a_ovf, 1'b1);
        check("ovf_pop", a_pop, 3'd4);
        step_a(1, 1, 16'h0055);
        check("fullrw_pop",  a_pop,  3'd4);
        check("fullrw_ovf",  a_ovf,  1'b1);
        check("fullrw_dout", a_dout, 16'h0011);
        check("rd_hold", a_dout, 16'h0011);
        step_a(0, 1, '0); check("rd_22", a_dout, 16'h0022);
        step_a(0, 1, '0); check("rd_33", a_dout, 16'h0033);
        step_a(0, 1, '0); check("rd_44", a_dout, 16'h0044);
        step_a(0, 1, '0); check("rd_55", a_dout, 16'h0055);
        check("drain_empty", a_empty, 1'b1);
        check("drain_ovf",   a_ovf,   1'b1);

        // underflow, and rd+wr on empty
        step_a(0, 1, '0);
        check("udf_set",  a_udf,  1'b1);
        check("udf_dout", a_dout, 16'h0055);
        step_a(1, 1, 16'h00AA);
        check("emptyrw_pop",  a_pop,  3'd1);
        check("emptyrw_udf",  a_udf,  1'b1);
        check("emptyrw_dout", a_dout, 16'h0055);

        clr_a();
        check("clr1_pop", a_pop, 3'd0);
        check("clr1_udf", a_udf, 1'b0);
        check("clr1_ovf", a_ovf, 1'b0);

        // pointer wrap: hold two words in flight while streaming ten pairs
        for (int i = 0; i < 2; i++) begin
            v = 16'h2000 + 16'(i);
            step_a(1, 0, v);
            exp_q.push_back(v);
        end
        for (int i = 0; i < 10; i++) begin
            v = 16'h1000 + 16'(i * 16'h0111);
            step_a(1, 1, v);
            exp_q.push_back(v);
            e = exp_q.pop_front();
            check($sformatf("wrap_dout%0d", i), a_dout, e);
            check($sformatf("wrap_pop%0d", i),  a_pop,  3'd2);
        end
        for (int i = 0; i < 2; i++) begin
            step_a(0, 1, '0);
            e = exp_q.pop_front();
            check($sformatf("wrap_drain%0d", i), a_dout, e);
        end
        check("wrap_empty", a_empty, 1'b1);

        // population 3 with overflow set, then clear
        for (int i = 1; i <= 5; i++) step_a(1, 0, 16'(i));
        step_a(0, 1, '0);
        check("pre_clr_pop",  a_pop,  3'd3);
        check("pre_clr_ovf",  a_ovf,  1'b1);
        check("pre_clr_dout", a_dout, 16'h0001);
        clr_a();
        check("clr2_pop",   a_pop,   3'd0);
        check("clr2_empty", a_empty, 1'b1);
        check("clr2_ovf",   a_ovf,   1'b0);

        // asynchronous reset in the middle of a write burst
        step_a(1, 0, 16'hBEEF);
        step_a(1, 0, 16'hCAFE);
        check("burst_pop", a_pop, 3'd2);
        a_wr = 1'b1; a_din = 16'hD00D;
        #2 rst = 1'b1;
        #1;
        check_reset_a("arst");
        @(posedge clk); #1;
        check("arst_hold_pop", a_pop, 3'd0);
        rst = 1'b0; a_wr = 1'b0;
        step_a(1, 0, 16'h0077);
        check("post_rst_pop", a_pop, 3'd1);
        step_a(0, 1, '0);
        check("post_rst_dout", a_dout, 16'h0077);

        // fall-through instance
        b_wr = 1'b1; b_din = 16'h1234;
        #1 check("fw_same_cycle", b_dout, 16'h0000);
        @(posedge clk); #1;
        b_wr = 1'b0;
        check("fw_1234",     b_dout, 16'h1234);
        check("fw_pop1",     b_pop,  3'd1);
        step_b(1, 0, 16'h5678);
        check("fw_head_hold", b_dout, 16'h1234);
        check("fw_pop2",      b_pop,  3'd2);
        step_b(0, 1, '0);
        check("fw_5678", b_dout, 16'h5678);
        step_b(0, 1, '0);
        check("fw_empty_dout", b_dout,  16'h0000);
        check("fw_empty",      b_empty, 1'b1);
        b_wr = 1'b1; b_rd = 1'b1; b_din = 16'hAAAA;
        #1 check("fw_rw_same_cycle", b_dout, 16'h0000);
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
        check("fw_rw_dout", b_dout, 16'hAAAA);
        check("fw_rw_pop",  b_pop,  3'd1);
        check("fw_rw_udf",  b_udf,  1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pea_fifo_ext.md
PEA_FIFO_EXT -- requirements
Module: pea_fifo_ext

Interface
REQ-001 SHALL have parameter buffer_size, default 1024, giving depth in words (power of two, >=2).
REQ-002 SHALL have parameter width, default 16, giving data word width in bits.
REQ-003 SHALL have parameter fwft, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter af_level, default buffer_size-2: almost-full threshold.
REQ-005 SHALL have parameter ae_level, default 2: almost-empty threshold.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port clr, input, 1, synchronous flush.
REQ-009 SHALL have port wr_en, input, 1, write request.
REQ-010 SHALL have port rd_en, input, 1, read (pop) request.
REQ-011 SHALL have port data_in, input, width, write data.
REQ-012 SHALL have port population, output, log2(buffer_size)+1, stored word count.
REQ-013 SHALL have port free_space, output, log2(buffer_size)+1, equal to buffer_size minus population.
REQ-014 SHALL have port data_out, output, width, read data.
REQ-015 SHALL have ports empty, full, almost_full and almost_empty, output, 1 each, status flags.
REQ-016 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-017 SHALL store words in a circular buffer with wr_ptr and rd_ptr of log2(buffer_size) bits, wrapping from buffer_size-1 to 0.
REQ-018 SHALL accept a write only when wr_en=1 and (full=0 or an accepted read occurs the same cycle).
REQ-019 SHALL accept a read only when rd_en=1 and empty=0.
REQ-020 SHALL update population on each edge by +1 (write only), -1 (read only) or 0 (both or neither accepted).
REQ-021 SHALL assert empty iff population=0 and full iff population=buffer_size, combinationally from registered state.
REQ-022 SHALL assert almost_full iff population>=af_level and almost_empty iff population<=ae_level.
REQ-023 SHALL, in fwft=0 mode, load data_out with the head word on the edge a read is accepted, and hold it otherwise (one-cycle read latency).
REQ-024 SHALL, in fwft=1 mode, drive data_out with the head word combinationally whenever empty=0; a read advances it to the next word; data_out is 0 while empty.
REQ-025 SHALL, on a simultaneous write and read with population=0, perform the write, ignore the read and set underflow; a write to an empty FIFO is visible in fwft mode the next cycle, never the same cycle.
REQ-026 SHALL, on a simultaneous write and read with population=buffer_size, perform both and leave population at buffer_size with no overflow.
REQ-027 SHALL set overflow on a rejected write and underflow on a rejected read; both remain set until rst or clr.
REQ-028 SHALL, on clr=1, zero the pointers, population, overflow and underflow on the next edge, ignoring any wr_en/rd_en that cycle; stored RAM contents need not be cleared.

Reset
REQ-029 SHALL, on rst=1, asynchronously force wr_ptr=0, rd_ptr=0, population=0, data_out=0, overflow=0 and underflow=0, giving empty=1, almost_empty=1, full=0, almost_full=0 and free_space=buffer_size.
REQ-030 SHALL discard any in-flight operation when rst asserts mid-operation and accept no write or read until the first edge after rst deasserts.

Verification (buffer_size=4, width=16, af_level=3, ae_level=1)
REQ-031 Write 0x0011, 0x0022, 0x0033, 0x0044 with fwft=0 -> population 1,2,3,4; almost_full at 3; full at 4; then four reads return 0x0011..0x0044, each one edge after its rd_en.
REQ-032 Fifth write while full -> data ignored, overflow=1 and sticky; then simultaneous wr(0x0055)+rd -> population stays 4, overflow stays 1, and the last read returns 0x0055.
REQ-033 rd_en on empty -> underflow=1 and data_out holds its prior value; simultaneous wr(0x00AA)+rd on empty -> population=1 and underflow=1.
REQ-034 fwft=1: write 0x1234 -> data_out=0x1234 the cycle after the write with no rd_en; write 0x5678, then rd_en -> data_out=0x5678 on the next cycle.
REQ-035 Run 10 write/read pairs to wrap the pointers twice -> data order preserved and population never above 4.
REQ-036 Population 3 with overflow set: pulse clr -> population=0, empty=1, overflow=0; assert rst asynchronously mid-burst -> all outputs reach their REQ-029 values before the next clk edge.
